// File: rtl/controle_varredura_servo.sv
// ---------------------------------------------------------------------------
// controle_varredura_servo
//
// Sweep sequencer for the sonar servo. Walks the servo through positions
// 0..7 and back (ping-pong). At every position it waits a mechanical
// settling time, then issues a one-cycle measurement request to the
// ultrasonic ranging block. It waits for that block's done pulse or a
// timeout, and then advances to the next position.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   ligar        in   sweep enable (level)
//   fim_medida   in   one-cycle done pulse from the ranging block
//   largura      out  [2:0] position code for the PWM generator (registered)
//   sentido      out  sweep direction, 0 = ascending, 1 = descending (registered)
//   medir        out  one-cycle measurement request (registered)
//   medida_ok    out  one-cycle pulse after fim_medida is accepted (registered)
//   erro_timeout out  one-cycle pulse after the measurement wait expires (registered)
//   db_estado    out  [2:0] current FSM state code, for debug
// ---------------------------------------------------------------------------
module controle_varredura_servo #(
   parameter int unsigned TEMPO_ASSENTAMENTO = 32'd25000000,
   parameter int unsigned TIMEOUT_MEDIDA     = 32'd2500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_medida,
   output logic [2:0] largura,
   output logic       sentido,
   output logic       medir,
   output logic       medida_ok,
   output logic       erro_timeout,
   output logic [2:0] db_estado
);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      ASSENTA = 3'd1,
      MEDE    = 3'd2,
      ESPERA  = 3'd3,
      PROXIMA = 3'd4
   } t_estado;

   localparam logic [31:0] C_ULT_ASSENTA = TEMPO_ASSENTAMENTO - 32'd1;
   localparam logic [31:0] C_ULT_ESPERA  = TIMEOUT_MEDIDA - 32'd1;

   t_estado     r_estado;
   t_estado     w_prox;
   logic [31:0] r_conta;
   logic [2:0]  r_largura;
   logic        r_sentido;
   logic        r_medir;
   logic        r_medida_ok;
   logic        r_erro_timeout;
   logic        w_aceita;
   logic        w_expira;
   logic [3:0]  w_posicao;

   // Next position in the ping-pong sweep, returned as {sentido, largura}.
   // The direction flips at the end stops so the code never wraps.
   function automatic logic [3:0] proxima_posicao(input logic [2:0] pos,
                                                  input logic       desc);
      logic [3:0] res;
      if (!desc && pos == 3'd7) begin
         res = {1'b1, 3'd6};
      end else if (desc && pos == 3'd0) begin
         res = {1'b0, 3'd1};
      end else if (desc) begin
         res = {1'b1, pos - 3'd1};
      end else begin
         res = {1'b0, pos + 3'd1};
      end
      return res;
   endfunction

   assign w_posicao = proxima_posicao(r_largura, r_sentido);

   // Next-state logic. In ESPERA, dropping ligar beats a simultaneous
   // fim_medida, and fim_medida beats a simultaneous timeout.
   always_comb begin
      w_prox   = r_estado;
      w_aceita = 1'b0;
      w_expira = 1'b0;
      case (r_estado)
         INICIAL: begin
            if (ligar) w_prox = ASSENTA;
         end
         ASSENTA: begin
            if (!ligar) begin
               w_prox = INICIAL;
            end else if (r_conta == C_ULT_ASSENTA) begin
               w_prox = MEDE;
            end
         end
         MEDE: begin
            w_prox = ESPERA;
         end
         ESPERA: begin
            if (!ligar) begin
               w_prox = INICIAL;
            end else if (fim_medida) begin
               w_prox   = PROXIMA;
               w_aceita = 1'b1;
            end else if (r_conta == C_ULT_ESPERA) begin
               w_prox   = PROXIMA;
               w_expira = 1'b1;
            end
         end
         PROXIMA: begin
            w_prox = ligar ? ASSENTA : INICIAL;
         end
         default: begin
            w_prox = INICIAL;
         end
      endcase
   end

   // State, dwell counter and registered outputs. The counter restarts on
   // every state change, so the ASSENTA/ESPERA dwell is measured from entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_estado       <= INICIAL;
         r_conta        <= '0;
         r_largura      <= 3'd0;
         r_sentido      <= 1'b0;
         r_medir        <= 1'b0;
         r_medida_ok    <= 1'b0;
         r_erro_timeout <= 1'b0;
      end else begin
         r_estado <= w_prox;
         if (w_prox != r_estado) begin
            r_conta <= '0;
         end else begin
            r_conta <= r_conta + 32'd1;
         end
         // medir is decoded from the next state so it is high exactly
         // during the MEDE cycle while still coming from a flop.
         r_medir        <= (w_prox == MEDE);
         r_medida_ok    <= w_aceita;
         r_erro_timeout <= w_expira;
         if (r_estado == PROXIMA) begin
            {r_sentido, r_largura} <= w_posicao;
         end
      end
   end

   assign largura      = r_largura;
   assign sentido      = r_sentido;
   assign medir        = r_medir;
   assign medida_ok    = r_medida_ok;
   assign erro_timeout = r_erro_timeout;
   assign db_estado    = r_estado;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// ---------------------------------------------------------------------------
// Testbench for controle_varredura_servo (TEMPO_ASSENTAMENTO=10,
// TIMEOUT_MEDIDA=20). Randomized ranging-block responses and stray done
// pulses; expectations come from a position-index model of the ping-pong
// sweep and from the settle/timeout dwell rules.
// ---------------------------------------------------------------------------
module tb_controle_varredura_servo;

   localparam int T  = 10;
   localparam int TO = 20;

   logic       clock;
   logic       reset;
   logic       ligar;
   logic       fim_medida;
   logic [2:0] largura;
   logic       sentido;
   logic       medir;
   logic       medida_ok;
   logic       erro_timeout;
   logic [2:0] db_estado;

   int n_checks;
   int n_falhas;
   int passo;
   int k;

   controle_varredura_servo #(
      .TEMPO_ASSENTAMENTO(T),
      .TIMEOUT_MEDIDA    (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ligar       (ligar),
      .fim_medida  (fim_medida),
      .largura     (largura),
      .sentido     (sentido),
      .medir       (medir),
      .medida_ok   (medida_ok),
      .erro_timeout(erro_timeout),
      .db_estado   (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog obtido=running esperado=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic verifica(input string tag, input logic [31:0] obs,
                           input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_falhas++;
         $display("FAIL %s obtido=%0d esperado=%0d", tag, obs, esp);
      end
   endtask

   // Position visited on measurement step n of the sweep: 0..7 then 6..1,
   // period 14.
   function automatic int pos_ref(input int n);
      int p;
      p = n % 14;
      return (p <= 7) ? p : 14 - p;
   endfunction

   // Direction flag held while sitting on step n: descending on the way
   // down, and still descending on 0 until that position is left.
   function automatic int sent_ref(input int n);
      int p;
      p = n % 14;
      return ((p > 7) || (p == 0 && n > 0)) ? 1 : 0;
   endfunction

   // Wait for medir; it must arrive after exactly 'esperado' clock edges.
   task automatic espera_medir(input int esperado, input bit stray);
      int n;
      bit visto;
      n = 0;
      visto = 1'b0;
      while (!visto && n < esperado + 40) begin
         fim_medida = stray && ($urandom_range(0, 3) == 0);
         tick();
         n++;
         if (medir) visto = 1'b1;
         else verifica("sem_pulso", 32'({medida_ok, erro_timeout}), 0);
      end
      fim_medida = stray && ($urandom_range(0, 1) == 0);
      verifica("medir_visto", 32'(visto), 1);
      verifica("latencia_medir", n, esperado);
      verifica("largura_medir", 32'(largura), pos_ref(passo));
      verifica("sentido_medir", 32'(sentido), sent_ref(passo));
      verifica("estado_mede", 32'(db_estado), 2);
   endtask

   // Starting in the medir cycle: answer with fim_medida while the wait has
   // run k cycles (k >= TO means never answer), then check the outcome and
   // the position step.
   task automatic responde(input int kr);
      int  jvisto;
      bit  visto;
      bit  foi_ok;
      visto  = 1'b0;
      jvisto = -1;
      foi_ok = 1'b0;
      for (int j = 0; j < TO + 6 && !visto; j++) begin
         tick();
         if (medida_ok || erro_timeout) begin
            visto      = 1'b1;
            jvisto     = j;
            foi_ok     = medida_ok;
            fim_medida = 1'b0;
            verifica("pulsos_exclusivos", 32'(medida_ok & erro_timeout), 0);
            verifica("medir_fora", 32'(medir), 0);
            verifica("largura_retida", 32'(largura), pos_ref(passo));
         end else begin
            verifica("medir_unico", 32'(medir), 0);
            fim_medida = (j == kr);
         end
      end
      fim_medida = 1'b0;
      verifica("resposta_vista", 32'(visto), 1);
      verifica("atraso_resposta", jvisto, (kr < TO) ? kr + 1 : TO);
      verifica("tipo_resposta", 32'(foi_ok), (kr < TO) ? 1 : 0);
      tick();
      passo++;
      verifica("pulso_unico", 32'({medida_ok, erro_timeout}), 0);
      verifica("largura_nova", 32'(largura), pos_ref(passo));
      verifica("sentido_novo", 32'(sentido), sent_ref(passo));
   endtask

   initial begin
      n_checks   = 0;
      n_falhas   = 0;
      passo      = 0;
      reset      = 1'b0;
      ligar      = 1'b0;
      fim_medida = 1'b0;
      repeat (3) tick();
      verifica("rst_largura", 32'(largura), 0);
      verifica("rst_sentido", 32'(sentido), 0);
      verifica("rst_pulsos", 32'({medir, medida_ok, erro_timeout}), 0);
      verifica("rst_estado", 32'(db_estado), 0);
      reset = 1'b1;
      tick();
      tick();
      verifica("inicial_ocioso", 32'(db_estado), 0);

      // Full sweep 0..7..0,1 with mixed responses: quick, tie on last wait
      // cycle, timeout, then random.
      ligar = 1'b1;
      for (int s = 0; s < 16; s++) begin
         espera_medir((s == 0) ? T + 1 : T, 1'b1);
         if (s == 0)      k = 3;
         else if (s == 1) k = TO - 1;
         else if (s == 2) k = TO + 3;
         else             k = $urandom_range(0, TO + 4);
         responde(k);
      end

      // Drop ligar while ASSENTA counts 5: back to INICIAL, position held,
      // then a full dwell again on re-enable.
      repeat (5) begin
         tick();
         verifica("assenta_sem_medir", 32'(medir), 0);
      end
      ligar = 1'b0;
      tick();
      verifica("queda_estado", 32'(db_estado), 0);
      verifica("queda_largura", 32'(largura), pos_ref(passo));
      repeat (4) begin
         tick();
         verifica("ocioso_sem_medir", 32'(medir), 0);
         verifica("ocioso_estado", 32'(db_estado), 0);
      end
      ligar = 1'b1;
      espera_medir(T + 1, 1'b0);
      responde(2);

      // Drop ligar in ESPERA together with fim_medida: the done is discarded.
      espera_medir(T, 1'b1);
      fim_medida = 1'b0;
      tick();
      tick();
      ligar      = 1'b0;
      fim_medida = 1'b1;
      tick();
      fim_medida = 1'b0;
      verifica("espera_queda_estado", 32'(db_estado), 0);
      verifica("espera_queda_ok", 32'({medida_ok, erro_timeout}), 0);
      repeat (3) begin
         tick();
         verifica("espera_queda_largura", 32'(largura), pos_ref(passo));
         verifica("espera_queda_pulsos", 32'({medir, medida_ok, erro_timeout}), 0);
      end
      ligar = 1'b1;
      espera_medir(T + 1, 1'b0);
      responde($urandom_range(0, TO + 4));

      // Advance to largura=5 descending, then reset in the middle of ESPERA.
      while (passo % 14 != 9) begin
         espera_medir(T, 1'b1);
         responde($urandom_range(0, TO + 4));
      end
      espera_medir(T, 1'b0);
      fim_medida = 1'b0;
      repeat (3) tick();
      verifica("pre_reset_estado", 32'(db_estado), 3);
      verifica("pre_reset_pos", 32'({sentido, largura}), 32'h0D);
      reset = 1'b0;
      tick();
      verifica("reset_largura", 32'(largura), 0);
      verifica("reset_sentido", 32'(sentido), 0);
      verifica("reset_estado", 32'(db_estado), 0);
      verifica("reset_pulsos", 32'({medir, medida_ok, erro_timeout}), 0);
      reset = 1'b1;
      passo = 0;

      // After reset: timeout at position 0 must still advance to 1.
      espera_medir(T + 1, 1'b0);
      responde(TO + 2);
      espera_medir(T, 1'b1);
      responde(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
      $finish;
   end

endmodule

// File: doc/controle_varredura_servo.md
Name: controle_varredura_servo

Overview:
- Sweep sequencer for the sonar servo. Sits directly upstream of the servo PWM generator and drives its 3-bit position code (largura).
- Steps the servo through 8 positions in a ping-pong pattern: 0→7→0→…
- At each position it waits for mechanical settling, then pulses a measurement request to the ultrasonic ranging block and waits for its done flag or a timeout before moving on.

Parameters:
- TEMPO_ASSENTAMENTO, 25000000, settle cycles per position (0.5 s @ 50 MHz); legal range ≥2.
- TIMEOUT_MEDIDA, 2500000, max cycles waiting for fim_medida (50 ms @ 50 MHz); legal range ≥2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ligar  in  1  sweep enable, level-sensitive.
- fim_medida  in  1  single-cycle done pulse from the ranging block.
- largura  out  3  position code to the PWM generator; registered.
- sentido  out  1  sweep direction: 0 = ascending, 1 = descending; registered.
- medir  out  1  single-cycle measurement request; registered.
- medida_ok  out  1  single-cycle pulse when fim_medida is accepted; registered.
- erro_timeout  out  1  single-cycle pulse when the wait expires; registered.
- db_estado  out  3  current FSM state code, for debug.

Behaviour:
- Reset (reset=0 at a rising edge) overrides everything, including mid-operation. Results after the edge:
  - state=INICIAL, largura=000, sentido=0, medir=0, medida_ok=0, erro_timeout=0, counter=0.
- Single 32-bit internal counter, cleared on every state entry. Widths are 32-bit unsigned; comparisons use PARAM-1.
- State codes: INICIAL=0, ASSENTA=1, MEDE=2, ESPERA=3, PROXIMA=4. Codes 5–7 are illegal and go to INICIAL next cycle.
- INICIAL: hold largura/sentido. ligar=1 → ASSENTA.
- ASSENTA: counter increments each cycle.
  - ligar=0 → INICIAL; largura is held, no medir.
  - counter==TEMPO_ASSENTAMENTO-1 → MEDE.
  - Net dwell in ASSENTA is exactly TEMPO_ASSENTAMENTO cycles.
- MEDE: lasts exactly 1 cycle, medir=1 (Moore output), always → ESPERA. ligar is not sampled here.
- ESPERA: counter increments.
  - Priority 1: ligar=0 → INICIAL; a fim_medida in the same cycle is discarded.
  - Priority 2: fim_medida=1 → PROXIMA, with medida_ok=1 in the cycle after acceptance.
  - Priority 3: counter==TIMEOUT_MEDIDA-1 → PROXIMA, with erro_timeout=1 in the cycle after.
  - fim_medida and timeout in the same cycle: fim_medida wins; no erro_timeout.
- fim_medida is ignored in every state except ESPERA.
- PROXIMA: lasts 1 cycle and updates the position:
  - sentido=0 & largura=7: sentido←1, largura←6.
  - sentido=1 & largura=0: sentido←0, largura←1.
  - Otherwise largura ±1 per sentido; never wraps.
  - Next state: ligar=1 → ASSENTA, else INICIAL.
- largura changes only in PROXIMA (or on reset). Re-enabling resumes from the held position and direction.
- Position period with immediate fim_medida at first ESPERA cycle: TEMPO_ASSENTAMENTO + 3 cycles (ASSENTA + MEDE + ESPERA + PROXIMA).
- medir, medida_ok and erro_timeout are each high for at most 1 cycle and never high simultaneously.

Test Plan (TEMPO_ASSENTAMENTO=10, TIMEOUT_MEDIDA=20):
- Reset then ligar=1, fim_medida returned 3 cycles after each medir:
  - first medir 11 cycles after ligar sampled high.
  - largura sequence 0,1,…,7,6,…,0,1.
  - sentido toggles after largura=7 and after largura=0.
- fim_medida never returned → erro_timeout pulses 20 cycles after medir; largura advances 0→1; medida_ok stays 0.
- fim_medida asserted on the same cycle the counter hits 19 → medida_ok=1, erro_timeout=0, largura advances once.
- ligar dropped at ASSENTA count 5:
  - INICIAL next cycle, no medir, largura held.
  - re-raising ligar gives a full 10-cycle dwell, then medir at the same largura.
- reset=0 asserted in ESPERA at largura=5, sentido=1 → next cycle largura=000, sentido=0, db_estado=0, all pulses 0.
- Stray fim_medida pulses during INICIAL/ASSENTA/MEDE → no state change, no medida_ok.
